prog_counter: RTL and testbench
===============================

// Module: prog_counter
// PURPOSE
// - Fetch-side program counter for the 8-bit core. Sits directly downstream of the ALU.
// - Consumes the ALU zero flag to resolve beq and produces the instruction-memory address.
// - Owns a small writable branch-target LUT indexed by the instruction's target field.
// - Wraps the program in a Start/Done run-control handshake.
// PARAMETERS
// - PC_W       10  width of program counter / instruction address
// - LUT_DEPTH  16  branch-target LUT entries; must be a power of 2
// - TGT_W      4   LUT index width; must equal log2(LUT_DEPTH)
// PORTS
// - Clk       in   1      rising-edge clock
// - Reset     in   1      asynchronous, active-high reset
// - Start     in   1      1-cycle pulse: (re)start program at PC 0
// - Halt      in   1      decoded halt instruction at current PC
// - Jump      in   1      decoded unconditional jump (j)
// - BranchEn  in   1      decoded beq
// - Zero      in   1      ALU zero flag; 1 = beq operands equal
// - Target    in   TGT_W  LUT index from instruction field
// - LutWe     in   1      LUT write enable
// - LutAddr   in   TGT_W  LUT write index
// - LutData   in   PC_W   LUT write data (absolute target)
// - ProgCtr   out  PC_W   instruction-memory address
// - Running   out  1      1 while in RUN
// - Done      out  1      1 while in HALT
// - BrTaken   out  16     count of taken jumps/branches (see CONFIGURATION)
// BEHAVIOUR
// - Reset (async, immediate):
//   - state=IDLE, ProgCtr=0, Running=0, Done=0, BrTaken=0.
//   - All LUT entries cleared to 0.
//   - Reset mid-run aborts with no further PC update.
// - States:
//   - IDLE: PC held at 0; Start -> RUN, PC=0.
//   - RUN: per cycle, priority order:
//     1. Start -> PC=0, stay RUN.
//     2. Halt -> HALT, PC held.
//     3. Jump -> PC=LUT[Target].
//     4. BranchEn & Zero -> PC=LUT[Target].
//     5. Otherwise PC=PC+1.
//   - HALT: PC held, Done=1; Start -> RUN, PC=0, Done=0 on the same edge.
// - Control inputs Halt/Jump/BranchEn/Zero/Target are ignored outside RUN.
// - Outputs are registered; Running/Done are decoded from the state register.
//   - Done rises the edge after Halt is sampled in RUN.
// - Next-address latency: 1 cycle (decision at edge N, new ProgCtr visible after edge N).
// - PC increment wraps modulo 2^PC_W (all-ones -> 0); no error flag.
// - BranchEn & ~Zero: not taken, PC+1.
// - Jump & BranchEn together: Jump wins, counts as one taken event.
// - LUT: synchronous write on LutWe in any state, including IDLE and HALT.
//   - Read is combinational from the pre-edge contents.
//   - Same-cycle write and taken branch on the same index: branch uses the OLD entry.
// CONFIGURATION
// - PC_PERF_CNT_EN defined:
//   - BrTaken increments by 1 on each taken Jump/branch in RUN; saturates at 16'hFFFF.
//   - Cleared by Reset and by Start.
// - PC_PERF_CNT_EN undefined:
//   - BrTaken tied to 0; no counter logic.
// TESTING
// 1. Reset asserted mid-RUN at PC=5 -> ProgCtr=0, Done=0, Running=0 immediately; LUT reads 0.
// 2. Start pulse, 3 idle cycles -> ProgCtr 0,1,2,3; Running=1.
//    PC=2^PC_W-1 with no control -> next PC=0.
// 3. LUT[3]=40; BranchEn=1, Target=3:
//    - Zero=1 -> PC=40 next cycle, BrTaken=1 (macro on).
//    - Zero=0 -> PC+1, BrTaken unchanged.
// 4. Jump=1 and BranchEn=1, Target=3, LUT[3]=40 -> PC=40, BrTaken +1 only.
//    LutWe to index 3 (data 99) in the same cycle -> PC=40, not 99.
// 5. Halt at PC=7:
//    - PC stays 7, Done=1 next cycle and held, Jump ignored.
//    - Start -> PC=0, Done=0, Running=1.
// 6. Macro off: run test 3 -> BrTaken stays 0.
//    Macro on: force 65536 taken branches -> BrTaken holds FFFF.

Source files
------------

// File: rtl/prog_counter.sv
// Fetch-side program counter with writable branch-target LUT and Start/Done run control.
// Define PC_PERF_CNT_EN to build the saturating taken-branch counter on BrTaken.
module prog_counter #(
    parameter int PC_W      = 10,
    parameter int LUT_DEPTH = 16,
    parameter int TGT_W     = 4
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             Jump,
    input  logic             BranchEn,
    input  logic             Zero,
    input  logic [TGT_W-1:0] Target,
    input  logic             LutWe,
    input  logic [TGT_W-1:0] LutAddr,
    input  logic [PC_W-1:0]  LutData,
    output logic [PC_W-1:0]  ProgCtr,
    output logic             Running,
    output logic             Done,
    output logic [15:0]      BrTaken
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    logic [1:0]      state_p0;
    logic [1:0]      state_nxt;
    logic [PC_W-1:0] pc_p0;
    logic [PC_W-1:0] pc_nxt;
    logic [PC_W-1:0] lut_p0 [LUT_DEPTH];
    logic [PC_W-1:0] lut_rd;
    logic            in_run;
    logic            taken;

    function automatic logic [PC_W-1:0] wrap_inc(input logic [PC_W-1:0] v);
        return v + PC_ONE;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Combinational read sees the pre-edge table, so a same-cycle write is not forwarded.
    assign lut_rd = lut_p0[Target];
    assign in_run = (state_p0 == ST_RUN);
    assign taken  = in_run && !Start && !Halt && (Jump || (BranchEn && Zero));

    always_comb begin
        state_nxt = state_p0;
        pc_nxt    = pc_p0;
        unique case (state_p0)
            ST_IDLE: begin
                if (Start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = '0;
                end
            end
            ST_RUN: begin
                if (Start) begin
                    pc_nxt = '0;
                end else if (Halt) begin
                    state_nxt = ST_HALT;
                end else if (taken) begin
                    pc_nxt = lut_rd;
                end else begin
                    pc_nxt = wrap_inc(pc_p0);
                end
            end
            ST_HALT: begin
                if (Start) begin
                    state_nxt = ST_RUN;
                    pc_nxt    = '0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                pc_nxt    = '0;
            end
        endcase
    end

    // Stage p0: run-control state and program counter
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_p0 <= ST_IDLE;
            pc_p0    <= '0;
        end else begin
            state_p0 <= state_nxt;
            pc_p0    <= pc_nxt;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < LUT_DEPTH; i++) begin
                lut_p0[i] <= '0;
            end
        end else if (LutWe) begin
            lut_p0[LutAddr] <= LutData;
        end
    end

`ifdef PC_PERF_CNT_EN
    logic [15:0] cnt_p0;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt_p0 <= '0;
        end else if (Start) begin
            cnt_p0 <= '0;
        end else if (taken) begin
            cnt_p0 <= sat_inc(cnt_p0);
        end
    end

    assign BrTaken = cnt_p0;
`else
    assign BrTaken = 16'd0;
`endif

    assign ProgCtr = pc_p0;
    assign Running = in_run;
    assign Done    = (state_p0 == ST_HALT);

endmodule

// File: tb/tb_prog_counter.sv
// Randomized self-checking bench for prog_counter against a behavioural model.
// Counter expectations follow PC_PERF_CNT_EN the same way the design build does.
module tb_prog_counter;

    localparam int PC_W      = 10;
    localparam int LUT_DEPTH = 16;
    localparam int TGT_W     = 4;

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic             Start = 1'b0;
    logic             Halt = 1'b0;
    logic             Jump = 1'b0;
    logic             BranchEn = 1'b0;
    logic             Zero = 1'b0;
    logic [TGT_W-1:0] Target = '0;
    logic             LutWe = 1'b0;
    logic [TGT_W-1:0] LutAddr = '0;
    logic [PC_W-1:0]  LutData = '0;
    logic [PC_W-1:0]  ProgCtr;
    logic             Running;
    logic             Done;
    logic [15:0]      BrTaken;

    prog_counter #(.PC_W(PC_W), .LUT_DEPTH(LUT_DEPTH), .TGT_W(TGT_W)) dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Jump(Jump),
        .BranchEn(BranchEn), .Zero(Zero), .Target(Target), .LutWe(LutWe),
        .LutAddr(LutAddr), .LutData(LutData), .ProgCtr(ProgCtr),
        .Running(Running), .Done(Done), .BrTaken(BrTaken)
    );

    always #5 Clk = ~Clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: mode 0 idle, 1 running, 2 halted
    int m_mode;
    int m_pc;
    int m_cnt;
    int m_lut [LUT_DEPTH];

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_cnt();
`ifdef PC_PERF_CNT_EN
        return m_cnt;
`else
        return 0;
`endif
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 0;
        m_cnt  = 0;
        for (int i = 0; i < LUT_DEPTH; i++) m_lut[i] = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},   int'(ProgCtr), m_pc);
        check({tag, ".run"},  int'(Running), (m_mode == 1) ? 1 : 0);
        check({tag, ".done"}, int'(Done),    (m_mode == 2) ? 1 : 0);
        check({tag, ".cnt"},  int'(BrTaken), exp_cnt());
    endtask

    task automatic cyc(input string tag, input bit st, input bit hl, input bit jp,
                       input bit be, input bit z, input int tg,
                       input bit we, input int wa, input int wd, input bit chk_en);
        int tval;
        @(negedge Clk);
        Start = st; Halt = hl; Jump = jp; BranchEn = be; Zero = z;
        Target = TGT_W'(tg); LutWe = we; LutAddr = TGT_W'(wa); LutData = PC_W'(wd);
        @(posedge Clk);
        tval = m_lut[tg];
        if (st) begin
            m_mode = 1;
            m_pc   = 0;
            m_cnt  = 0;
        end else if (m_mode == 1) begin
            if (hl) begin
                m_mode = 2;
            end else if (jp || (be && z)) begin
                m_pc  = tval;
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
            end else begin
                m_pc = (m_pc + 1) % (1 << PC_W);
            end
        end
        if (we) m_lut[wa] = wd;
        #1;
        if (chk_en) check_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    endtask

    task automatic wr(input string tag, input int a, input int d);
        cyc(tag, 0, 0, 0, 0, 0, 0, 1, a, d, 1);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge Clk);
        Reset = 1'b0;

        // Abort mid-run at PC 5 after dirtying the table
        wr("wr2", 2, 123);
        cyc("start0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) idle("run5");
        check("pc_at5", int'(ProgCtr), 5);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge Clk);
        Reset = 1'b0;
        cyc("start1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("lut_cleared", 0, 0, 1, 0, 0, 2, 0, 0, 0, 1);

        // Sequential fetch and wrap
        cyc("start2", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 3; i++) begin
            idle("seq");
            check("seq_pc", int'(ProgCtr), i);
        end
        wr("wr1", 1, (1 << PC_W) - 1);
        cyc("jmp_top", 0, 0, 1, 0, 0, 1, 0, 0, 0, 1);
        idle("wrap");
        check("wrap_zero", int'(ProgCtr), 0);

        // beq taken / not taken
        wr("wr3", 3, 40);
        cyc("beq_t", 0, 0, 0, 1, 1, 3, 0, 0, 0, 1);
        check("beq_t_pc", int'(ProgCtr), 40);
        cyc("beq_nt", 0, 0, 0, 1, 0, 3, 0, 0, 0, 1);
        check("beq_nt_pc", int'(ProgCtr), 41);

        // Jump+beq with same-cycle write to that entry
        cyc("jb_wr", 0, 0, 1, 1, 1, 3, 1, 3, 99, 1);
        check("jb_old", int'(ProgCtr), 40);
        cyc("jb_new", 0, 0, 1, 0, 0, 3, 0, 0, 0, 1);

        // Halt at PC 7, control ignored, restart
        wr("wr4", 4, 7);
        cyc("to7", 0, 0, 1, 0, 0, 4, 0, 0, 0, 1);
        cyc("halt", 0, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        check("halt_done", int'(Done), 1);
        cyc("halt_jmp", 0, 0, 1, 1, 1, 3, 0, 0, 0, 1);
        check("halt_pc", int'(ProgCtr), 7);
        wr("halt_wr", 6, 300);
        cyc("restart", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc("halt_lut", 0, 0, 1, 0, 0, 6, 0, 0, 0, 1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cyc("rnd", ($urandom_range(0, 40) == 0), ($urandom_range(0, 30) == 0),
                ($urandom_range(0, 5) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                $urandom_range(0, LUT_DEPTH - 1), ($urandom_range(0, 3) == 0),
                $urandom_range(0, LUT_DEPTH - 1), $urandom_range(0, (1 << PC_W) - 1), 1);
        end

`ifdef PC_PERF_CNT_EN
        // Counter saturation
        cyc("sat_start", 1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 65540; i++) cyc("sat", 0, 0, 1, 0, 0, 5, 0, 0, 0, 0);
        check_all("sat_end");
        check("sat_ffff", int'(BrTaken), 65535);
`endif

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
